memory_unit: RTL
================

MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 Parameter ADDR_W, default 4, address width; the module SHALL size the MAR, program-load address and RAM depth (2^ADDR_W) from it.
REQ-002 Parameter DATA_W, default 8, data width; the module SHALL size bus and RAM words from it.
REQ-003 clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 bus_in  input  DATA_W  shared CPU bus value; MAR loads from bits [ADDR_W-1:0].
REQ-006 lm  input  1  load MAR from bus_in, active-high.
REQ-007 ce  input  1  drive RAM[MAR] onto the bus, active-high.
REQ-008 ri  input  1  write bus_in into RAM[MAR], active-high.
REQ-009 bus_out  output  DATA_W  RAM read data.
REQ-010 bus_drive  output  1  bus_out is valid and owns the bus.
REQ-011 prog_mode  input  1  external program-load mode, level, assumed stable over several cycles.
REQ-012 prog_data  input  DATA_W  program byte, held stable while prog_strobe is high.
REQ-013 prog_strobe  input  1  asynchronous load strobe from pins.
REQ-014 prog_addr  output  ADDR_W  next program-load address.
REQ-015 prog_ack  output  1  one-cycle pulse after each program-load write.
REQ-016 prog_done  output  1  all 2^ADDR_W locations loaded.

Function
REQ-017 The FSM SHALL have states RUN, PROG and DONE.
REQ-018 Transitions: RUN->PROG when prog_mode=1; PROG->DONE on the write to address 2^ADDR_W-1; PROG or DONE->RUN when prog_mode=0; all others hold.
REQ-019 In RUN, lm=1 SHALL load MAR with bus_in[ADDR_W-1:0] at the clock edge.
REQ-020 In RUN, ri=1 SHALL write bus_in to RAM[MAR] at the clock edge; when lm and ri are both asserted, the write SHALL use the pre-edge MAR.
REQ-021 bus_out SHALL equal RAM[MAR] combinationally, with zero cycles of read latency.
REQ-022 bus_drive SHALL be 1 only in RUN with ce=1 and ri=0; ce with ri SHALL write and keep bus_drive=0.
REQ-023 In PROG and DONE, lm, ri and ce SHALL be ignored and bus_drive SHALL be 0.
REQ-024 prog_strobe SHALL pass through a 2-FF synchronizer and a rising-edge detector; level-high strobes SHALL yield exactly one write.
REQ-025 In PROG, a detected edge SHALL write prog_data to RAM[prog_addr], increment prog_addr modulo 2^ADDR_W, and assert prog_ack for the following cycle.
REQ-026 The write SHALL commit at the third rising clk edge after prog_strobe rises (setup met at the first edge).
REQ-027 prog_done SHALL be 1 exactly while in DONE; edges detected in DONE or RUN SHALL be discarded.
REQ-028 Entering PROG from RUN SHALL clear prog_addr to 0; leaving to RUN SHALL clear prog_addr and prog_done.
REQ-029 prog_mode falling mid-load SHALL abandon the sequence while retaining any bytes already written.

Reset
REQ-030 On rst_n=0, without waiting for clk, the block SHALL set the FSM to RUN and clear MAR, prog_addr, all RAM words, the synchronizer and edge flops, prog_ack and prog_done.
REQ-031 During and immediately after reset, bus_out=0 and bus_drive=0 until ce is asserted.

Structure
REQ-032 ADDR_W/DATA_W defaults and the RUN/PROG/DONE encodings SHALL live in the shared package cpu_pkg.
REQ-033 The synchronizer plus edge detector SHALL be the sub-module strobe_sync; RAM and MAR SHALL stay inline.

Verification
REQ-034 Reset, then lm=1 with bus_in=0x05, ri=1 with bus_in=0xA7, then ce=1 -> bus_out=0xA7, bus_drive=1.
REQ-035 Same cycle: lm=1 with bus_in=0x03 and ri=1 with MAR=0x05 -> RAM[5] written, RAM[3] unchanged, MAR=3 afterwards.
REQ-036 prog_mode=1, 16 strobes with data 0x10..0x1F -> prog_ack pulses 16 times, prog_done=1; prog_mode=0, read addresses 0..15 -> 0x10..0x1F.
REQ-037 prog_strobe held high for 10 cycles with data 0x55 -> exactly one write at address 0, prog_addr=1, a single prog_ack.
REQ-038 Drop prog_mode after 4 loads, raise it again, then 1 strobe with 0x99 -> RAM[0]=0x99, prog_addr=1, RAM[1..3] hold the earlier bytes.
REQ-039 rst_n pulsed low mid-PROG and mid-ri -> all state zero immediately, FSM in RUN, no partial write.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU memory blocks.
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   state_t                 : program-load FSM state encoding
package cpu_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_PROG = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/strobe_sync.sv
// strobe_sync: brings an asynchronous strobe into the clk domain and flags
// its rising edge. The output is a single-cycle pulse, however long the strobe
// stays high.
//   clk, rst_n   : clock, asynchronous active-low reset
//   strobe_async : raw strobe from the pins
//   rise         : one-cycle pulse on a synchronized rising edge
module strobe_sync
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_async,
  output logic rise
);

  logic sync_q1;
  logic sync_q2;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q1 <= strobe_async;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  // A strobe that is set up before edge 1 reaches sync_q2 at edge 2, so the
  // write it triggers commits at edge 3.
  assign rise = sync_q2 & ~prev_q;

endmodule

// File: rtl/memory_unit.sv
// memory_unit: CPU RAM with memory address register (MAR) and an external
// program-load path.
//   clk, rst_n              : clock, asynchronous active-low reset
//   bus_in, lm, ce, ri      : CPU bus value, load MAR, drive bus, write RAM
//   bus_out, bus_drive      : RAM[MAR] read data and bus ownership
//   prog_mode, prog_data,
//   prog_strobe             : external loader controls (strobe is asynchronous)
//   prog_addr, prog_ack,
//   prog_done               : load address, per-write ack, all words loaded
//
// state | meaning
// RUN   | normal CPU access through MAR; loader edges discarded
// PROG  | loader writes prog_data to successive addresses; CPU controls ignored
// DONE  | last address written; waiting for prog_mode to drop
module memory_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              lm,
  input  logic              ce,
  input  logic              ri,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  input  logic              prog_mode,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_strobe,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              prog_ack,
  output logic              prog_done
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] prog_addr_q;
  logic [DATA_W-1:0] ram [DEPTH];
  logic              ack_q;

  logic              strobe_rise;
  logic              run_wr;
  logic              prog_wr;
  logic              mar_ld;
  logic              addr_clr;
  logic              last_addr;

  strobe_sync u_strobe_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .strobe_async (prog_strobe),
    .rise         (strobe_rise)
  );

  assign last_addr = (prog_addr_q == {ADDR_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run_wr    = 1'b0;
    prog_wr   = 1'b0;
    mar_ld    = 1'b0;
    addr_clr  = 1'b0;
    bus_drive = 1'b0;
    case (state)
      ST_RUN: begin
        mar_ld    = lm;
        run_wr    = ri;
        bus_drive = ce & ~ri;
        // Holding the address at zero in RUN makes PROG always start at 0.
        addr_clr  = 1'b1;
        if (prog_mode) state_nxt = ST_PROG;
      end
      ST_PROG: begin
        // Dropping prog_mode wins over a coincident strobe: the load is abandoned.
        if (!prog_mode) begin
          state_nxt = ST_RUN;
          addr_clr  = 1'b1;
        end else if (strobe_rise) begin
          prog_wr = 1'b1;
          if (last_addr) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!prog_mode) begin
          state_nxt = ST_RUN;
          addr_clr  = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar         <= '0;
      prog_addr_q <= '0;
      ack_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      ack_q <= prog_wr;
      // MAR updates after the write below samples it, so lm+ri writes to the old MAR.
      if (mar_ld) mar <= bus_in[ADDR_W-1:0];
      if (run_wr)       ram[mar]         <= bus_in;
      else if (prog_wr) ram[prog_addr_q] <= prog_data;
      if (addr_clr)     prog_addr_q <= '0;
      else if (prog_wr) prog_addr_q <= prog_addr_q + ADDR_W'(1);
    end
  end

  assign bus_out   = ram[mar];
  assign prog_addr = prog_addr_q;
  assign prog_ack  = ack_q;
  assign prog_done = (state == ST_DONE);

endmodule
